// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencer (load-use, redirect, data-memory wait, timeout watchdog).
// Latency: control outputs are combinational from state and inputs; mem_err and counters are registered.
// Backpressure: dmem_ready low freezes the pipeline; optional counters built with PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_jump,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic [1:0]       pc_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       br_taken, load_use, redirect;

  // Raw hazard terms; register 0 never carries a real dependency
  always_comb begin
    br_taken = mem_branch & mem_zero;
    load_use = ex_memread && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

  // Next state and control outputs; memory stall outranks redirect, which outranks load-use.
  // wait_cnt counts held MEM_WAIT cycles, so a timeout holds request + MEM_TIMEOUT cycles.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    dmem_req    = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    pc_sel      = 2'b00;
    redirect    = 1'b0;
    if (rst) begin
      state_d    = RUN;
      wait_cnt_d = 8'd0;
      mem_err_d  = 1'b0;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      if (state_q == RUN) begin
        if (mem_memread | mem_memwrite) begin
          dmem_req = 1'b1;
          if (!dmem_ready) begin
            pipe_hold  = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = 8'd0;
          end
        end
      end else begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == 8'(MEM_TIMEOUT)) begin
          state_d   = RUN;
          mem_err_d = 1'b1;
        end else begin
          pipe_hold  = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      if (pipe_hold) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end else if (mem_jump | br_taken) begin
        redirect    = 1'b1;
        pc_sel      = mem_jump ? 2'b10 : 2'b01;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // State, wait counter and sticky error register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Saturating stall / redirect counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios followed by random traffic.
// Expected outputs come from a cycle-age model of the memory access and are queued per cycle.
// A negedge monitor pops and compares every presented output vector.
module tb_pipe_hazard_ctrl;
  localparam int MT    = 4;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 0, ex_memread = 0, mem_branch = 0, mem_zero = 0, mem_jump = 0;
  logic mem_memread = 0, mem_memwrite = 0, dmem_ready = 0;
  logic dmem_req, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold, mem_err;
  logic [1:0] pc_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_jump(mem_jump), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pipe_hold(pipe_hold), .pc_sel(pc_sel), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [10+2*CNT_W-1:0] vec_t;
  vec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model: age of the outstanding access (-1 = none), sticky error, counters
  int              age = -1;
  logic            m_err = 1'b0;
  logic [CNT_W-1:0] m_stall = '0, m_flush = '0;

  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic exr, input logic [4:0] exrt,
                      input logic br, input logic z, input logic j,
                      input logic mr, input logic mw, input logic rdy);
    logic e_dreq, e_pcw, e_ifw, e_iff, e_ief, e_emf, e_hold, busy, stalled, redir;
    logic [1:0] e_sel;
    int cur_age;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = exr; ex_rt = exrt;
    mem_branch = br; mem_zero = z; mem_jump = j; mem_memread = mr; mem_memwrite = mw;
    dmem_ready = rdy;
    e_dreq = 0; e_pcw = 1; e_ifw = 1; e_iff = 0; e_ief = 0; e_emf = 0; e_hold = 0;
    e_sel = 2'b00; stalled = 0; redir = 0; busy = 0; cur_age = 0;
    if (r) begin
      e_pcw = 0; e_ifw = 0;
    end else begin
      busy    = (age >= 0) || mr || mw;
      cur_age = (age >= 0) ? age : 0;
      if (busy) begin
        e_dreq = 1;
        // hold on the request cycle (age 0) and MT further cycles, then give up
        stalled = !rdy && (cur_age <= MT);
      end
      if (stalled) begin
        e_pcw = 0; e_ifw = 0; e_hold = 1;
      end else if (j || (br && z)) begin
        redir = 1; e_sel = j ? 2'b10 : 2'b01; e_iff = 1; e_ief = 1; e_emf = 1;
      end else if (exr && exrt != 0 && (exrt == rs || (urt && exrt == rt))) begin
        e_pcw = 0; e_ifw = 0; e_ief = 1;
      end
    end
`ifdef PIPE_CTRL_PERF_EN
    exp_q.push_back({e_dreq, e_pcw, e_ifw, e_iff, e_ief, e_emf, e_hold, e_sel, m_err, m_stall, m_flush});
`else
    exp_q.push_back({e_dreq, e_pcw, e_ifw, e_iff, e_ief, e_emf, e_hold, e_sel, m_err,
                     {CNT_W{1'b0}}, {CNT_W{1'b0}}});
`endif
    if (r) begin
      age = -1; m_err = 0; m_stall = '0; m_flush = '0;
    end else begin
      if (stalled) age = cur_age + 1;
      else begin
        if (busy && !rdy) m_err = 1;
        age = -1;
      end
      if (!e_pcw && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1;
      if (redir && m_flush != {CNT_W{1'b1}}) m_flush = m_flush + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation
  always @(negedge clk) begin
    vec_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {dmem_req, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold,
           pc_sel, mem_err, stall_cnt, flush_cnt};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d {dreq,pcw,ifw,iff,ief,emf,hold,sel,err,stall,flush} got=%h want=%h",
                 cyc, a, e);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    // reset-state checks
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // load-use, then hazard cleared
    step(0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, 0, 0, 0);
    idle(1);
    // rt-side hazard and rt not used
    step(0, 5'd1, 5'd7, 1, 1, 5'd7, 0, 0, 0, 0, 0, 0);
    step(0, 5'd1, 5'd7, 0, 1, 5'd7, 0, 0, 0, 0, 0, 0);
    // zero register
    step(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0, 0, 0);
    // branch overriding load-use; jump + branch; untaken branch
    step(0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 1, 0, 0, 0, 0);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 1, 1, 1, 0, 0, 0);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0);
    // single-cycle memory
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 0, 1, 1);
    // ready 3 cycles after request
    for (int i = 0; i < 3; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 1, 0, 0);
    step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 1, 0, 1);
    idle(1);
    // timeout: request + MT hold cycles + release, then sticky error
    for (int i = 0; i < MT + 2; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 1, 0, 0);
    idle(3);
    // reset during MEM_WAIT after 2 wait cycles
    for (int i = 0; i < 3; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 0, 1, 0);
    step(1, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 0, 1, 0);
    idle(2);
    // random traffic over a small register set so hazards are frequent
    for (int n = 0; n < 1500; n++) begin
      logic mr, mw, br, j;
      mr = ($urandom_range(0, 3) == 0);
      mw = !mr && ($urandom_range(0, 7) == 0);
      br = ($urandom_range(0, 4) == 0);
      j  = ($urandom_range(0, 9) == 0);
      if (mr || mw) begin br = 0; j = 0; end
      step($urandom_range(0, 60) == 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           br, 1'($urandom_range(0, 1)), j, mr, mw, $urandom_range(0, 9) < 4);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
